// File: rtl/act_load_unit.sv
// Copies a layer's activations from the activation buffer into the next layer's input region.
// Define ACT_LOAD_ARGMAX_EN to build the output-layer argmax (pred/pred_valid).
module act_load_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned NO_HL  = 2,
  parameter int unsigned NO_NIL = 784,
  parameter int unsigned NO_NHL = 28,
  parameter int unsigned NO_NOL = 10,
  localparam int unsigned RA_W  = $clog2(NO_NHL),
  localparam int unsigned LI_W  = $clog2(NO_HL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              net_done,
  output logic [RA_W-1:0]   act_rd_addr,
  input  logic [DATA_W-1:0] act_rd_data,
  output logic              ip_wr_en,
  output logic [ADDR_W-1:0] ip_wr_addr,
  output logic [DATA_W-1:0] ip_wr_data,
  output logic              load_done,
  output logic              busy,
  output logic [LI_W-1:0]   layer_idx,
  output logic [3:0]        pred,
  output logic              pred_valid
);

  localparam int unsigned CNT_W = $clog2(NO_NHL + 1);

  typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

  state_e              state_q, state_d;
  logic                armed_q;
  logic [LI_W-1:0]     layer_q;
  logic [CNT_W-1:0]    len_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    rd_idx_q;
  logic                rd_v_q;
  logic [CNT_W-1:0]    rd_i_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [CNT_W-1:0]    wr_i_q;

  logic                start;
  logic                rd_active;
  logic                last_wr;
  logic                is_out;
  logic [CNT_W-1:0]    len;
  logic [ADDR_W-1:0]   base;

  assign is_out    = (layer_q >= LI_W'(NO_HL));
  assign len       = is_out ? CNT_W'(NO_NOL) : CNT_W'(NO_NHL);
  assign base      = ADDR_W'(NO_NIL) + ADDR_W'(layer_q) * ADDR_W'(NO_NHL);
  assign start     = (state_q == StIdle) && load_en && armed_q;
  assign rd_active = (state_q == StCopy) && (rd_idx_q < len_q);
  assign last_wr   = wr_en_q && (wr_i_q == len_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCopy;
      StCopy:  if (last_wr) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Copy length and base are latched at the trigger so a mid-copy net_done cannot
  // change the transfer that is already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      armed_q   <= 1'b1;
      layer_q   <= '0;
      len_q     <= '0;
      base_q    <= '0;
      rd_idx_q  <= '0;
      rd_v_q    <= 1'b0;
      rd_i_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_i_q    <= '0;
    end else begin
      state_q <= state_d;

      if (start) begin
        armed_q <= 1'b0;
      end else if (!load_en) begin
        armed_q <= 1'b1;
      end

      if (start) begin
        rd_idx_q <= '0;
        len_q    <= len;
        base_q   <= base;
      end else if (rd_active) begin
        rd_idx_q <= rd_idx_q + CNT_W'(1);
      end

      rd_v_q  <= rd_active;
      rd_i_q  <= rd_idx_q;
      wr_en_q <= rd_v_q;
      if (rd_v_q) begin
        wr_addr_q <= base_q + ADDR_W'(rd_i_q);
        wr_data_q <= act_rd_data;
        wr_i_q    <= rd_i_q;
      end

      if (net_done) begin
        layer_q <= '0;
      end else if (state_q == StDone) begin
        layer_q <= (layer_q == LI_W'(NO_HL)) ? '0 : layer_q + LI_W'(1);
      end
    end
  end

  assign act_rd_addr = rd_active ? RA_W'(rd_idx_q) : '0;
  assign ip_wr_en    = wr_en_q;
  assign ip_wr_addr  = wr_addr_q;
  assign ip_wr_data  = wr_data_q;
  assign load_done   = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign layer_idx   = layer_q;

`ifdef ACT_LOAD_ARGMAX_EN
  logic                     is_out_q;
  logic signed [DATA_W-1:0] max_q;
  logic [3:0]               max_i_q;
  logic [3:0]               pred_q;
  logic                     pred_v_q;
  logic                     take;
  logic [3:0]               cand_i;

  // Strict greater-than so ties keep the earlier (lower) index.
  assign take   = wr_en_q && ((wr_i_q == '0) || ($signed(wr_data_q) > max_q));
  assign cand_i = take ? 4'(wr_i_q) : max_i_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_out_q <= 1'b0;
      max_q    <= '0;
      max_i_q  <= '0;
      pred_q   <= '0;
      pred_v_q <= 1'b0;
    end else begin
      if (start) begin
        is_out_q <= is_out;
      end
      if (is_out_q && (state_q == StCopy) && take) begin
        max_q   <= $signed(wr_data_q);
        max_i_q <= 4'(wr_i_q);
      end
      pred_v_q <= is_out_q && (state_q == StCopy) && last_wr;
      if (is_out_q && (state_q == StCopy) && last_wr) begin
        pred_q <= cand_i;
      end
    end
  end

  assign pred       = pred_q;
  assign pred_valid = pred_v_q;
`else
  assign pred       = 4'd0;
  assign pred_valid = 1'b0;
`endif

endmodule

// File: tb/tb_act_load_unit.sv
// Scoreboard bench for act_load_unit: expected writes are queued by stimulus and
// popped by a negedge monitor whenever ip_wr_en is seen.
module tb_act_load_unit;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        net_done;
  logic [4:0]  act_rd_addr;
  logic [7:0]  act_rd_data;
  logic        ip_wr_en;
  logic [10:0] ip_wr_addr;
  logic [7:0]  ip_wr_data;
  logic        load_done;
  logic        busy;
  logic [1:0]  layer_idx;
  logic [3:0]  pred;
  logic        pred_valid;

  act_load_unit dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .net_done    (net_done),
    .act_rd_addr (act_rd_addr),
    .act_rd_data (act_rd_data),
    .ip_wr_en    (ip_wr_en),
    .ip_wr_addr  (ip_wr_addr),
    .ip_wr_data  (ip_wr_data),
    .load_done   (load_done),
    .busy        (busy),
    .layer_idx   (layer_idx),
    .pred        (pred),
    .pred_valid  (pred_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:31];
  always @(posedge clk) act_rd_data <= mem[act_rd_addr];

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;
  int exp_addr [$];
  int exp_data [$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every write strobe against the head of the scoreboard.
  always @(negedge clk) begin
    int ea, ed;
    if (ip_wr_en) begin
      n_chk++;
      if (exp_addr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, none expected",
                 ip_wr_addr, ip_wr_data);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (int'(ip_wr_addr) != ea || int'(ip_wr_data) != ed) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                   ip_wr_addr, ip_wr_data, ea, ed);
        end
      end
    end
    if (load_done) done_seen++;
  end

  task automatic do_load(input int layer, input int exp_next);
    int n, base, cnt;
    n    = (layer < 2) ? 28 : 10;
    base = 784 + layer * 28;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + i);
      exp_data.push_back(int'(mem[i]));
    end
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (load_done) break;
    end
    check("done_latency", cnt, n + 2);
    check("busy_in_done", int'(busy), 1);
`ifdef ACT_LOAD_ARGMAX_EN
    if (layer == 2) begin
      check("pred_valid_with_done", int'(pred_valid), 1);
      check("pred", int'(pred), 1);
    end else begin
      check("pred_valid_hidden", int'(pred_valid), 0);
    end
`else
    check("pred_valid_off", int'(pred_valid), 0);
    check("pred_off", int'(pred), 0);
`endif
    @(posedge clk);
    #1;
    check("done_one_cycle", int'(load_done), 0);
    check("layer_after", int'(layer_idx), exp_next);
    check("queue_drained", exp_addr.size(), 0);
  endtask

  task automatic drop_en();
    @(negedge clk);
    load_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int argmax_vec [10] = '{3, 9, -2, 9, 0, 1, 5, 7, 8, 2};
    rst = 1'b1;
    load_en = 1'b0;
    net_done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_wr_en", int'(ip_wr_en), 0);
    check("rst_done", int'(load_done), 0);
    check("rst_layer", int'(layer_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Layer 0, data = index+1
    for (int i = 0; i < 28; i++) mem[i] = 8'(i + 1);
    do_load(0, 1);

    // load_en still high: must not retrigger
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("no_retrigger_busy", int'(busy), 0);
    end
    drop_en();

    for (int i = 0; i < 28; i++) mem[i] = 8'(100 + i);
    do_load(1, 2);
    drop_en();

    for (int i = 0; i < 10; i++) mem[i] = 8'(argmax_vec[i]);
    do_load(2, 0);
`ifdef ACT_LOAD_ARGMAX_EN
    @(posedge clk);
    #1;
    check("pred_hold", int'(pred), 1);
    check("pred_valid_pulse", int'(pred_valid), 0);
`endif
    drop_en();

    // Reset at the 10th write of a layer-0 copy
    for (int i = 0; i < 28; i++) mem[i] = 8'(50 + i);
    for (int i = 0; i < 10; i++) begin
      exp_addr.push_back(784 + i);
      exp_data.push_back(50 + i);
    end
    d0 = done_seen;
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1;
    check("tenth_write_live", int'(ip_wr_en), 1);
    check("tenth_write_addr", int'(ip_wr_addr), 793);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_wr_en", int'(ip_wr_en), 0);
    check("arst_wr_addr", int'(ip_wr_addr), 0);
    check("arst_wr_data", int'(ip_wr_data), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_rd_addr", int'(act_rd_addr), 0);
    check("arst_queue", exp_addr.size(), 0);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    check("no_done_after_rst", done_seen, d0);
    check("layer_after_rst", int'(layer_idx), 0);

    do_load(0, 1);
    drop_en();

    // net_done while layer_idx=1 clears the layer
    @(negedge clk);
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
    check("net_done_clear", int'(layer_idx), 0);
    for (int i = 0; i < 28; i++) mem[i] = 8'(200 + i);
    do_load(0, 1);
    drop_en();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
